div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have a single clock domain, i_clk; reset is synchronous and active-high.
REQ-002 i_clk  in  1  clock; all state updates on rising edge.
REQ-003 i_rst  in  1  synchronous active-high reset.
REQ-004 i_valid  in  1  request present; sampled only while o_ready=1.
REQ-005 i_op  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0] of RV32M divide group).
REQ-006 i_rs1  in  32  dividend.
REQ-007 i_rs2  in  32  divisor.
REQ-008 i_kill  in  1  pipeline flush; abandons any in-flight operation.
REQ-009 o_ready  out  1  unit idle and able to accept a request.
REQ-010 o_valid  out  1  single-cycle pulse; o_result valid while high.
REQ-011 o_result  out  32  quotient or remainder per latched i_op.

Function
REQ-012 SHALL implement states IDLE, CALC, DONE; o_ready = (state==IDLE) and not i_rst.
REQ-013 Accept SHALL occur on an edge where state==IDLE, i_valid=1, i_kill=0; latch op, operand signs, operand magnitudes.
REQ-014 Signed ops (DIV, REM) SHALL use two's-complement magnitudes; unsigned ops use operands unchanged.
REQ-015 Divisor zero at accept SHALL go IDLE->DONE; result all-ones for DIV/DIVU, i_rs1 for REM/REMU.
REQ-016 DIV/REM with i_rs1=0x80000000, i_rs2=0xFFFFFFFF SHALL go IDLE->DONE; DIV result 0x80000000, REM result 0.
REQ-017 All other accepts SHALL go IDLE->CALC with 5-bit iteration counter = 31.
REQ-018 CALC SHALL perform one restoring shift-subtract step per cycle using a 33-bit subtractor; remainder register updates only when difference bit 32 is 0; quotient bit = inverted bit 32.
REQ-019 CALC SHALL run exactly 32 cycles; on the edge where counter==0 transition to DONE; counter decrements otherwise.
REQ-020 DONE SHALL last exactly one cycle with o_valid=1, then return to IDLE; no accept possible during DONE.
REQ-021 Latency: normal op o_valid in the 33rd cycle after accept edge; special case (REQ-015/016) in the 1st cycle after accept edge.
REQ-022 Sign correction in DONE: quotient negated when signed op and operand signs differ; remainder negated when signed op and dividend negative.
REQ-023 o_result SHALL hold last produced value when o_valid=0 (no X, no intermediate state exposed).
REQ-024 i_kill=1 in any state SHALL force IDLE on next edge; no o_valid for killed op; i_kill has priority over accept and over DONE (o_valid forced 0 in that cycle).
REQ-025 Back-to-back: earliest next accept is the cycle after DONE (IDLE cycle).
REQ-026 i_valid, i_op, i_rs1, i_rs2 SHALL be ignored outside IDLE; unit does not require operands to remain stable after accept.

Reset
REQ-027 i_rst=1 SHALL, on the edge, force state IDLE, counter 0, quotient/remainder/o_result registers 0.
REQ-028 While i_rst=1: o_valid=0, o_ready=0; reset SHALL take priority over i_kill and i_valid.
REQ-029 Reset mid-CALC SHALL abandon the op with no o_valid; o_ready=1 the first cycle after i_rst deasserts.

Verification
REQ-030 DIVU 100/7 accepted at edge T -> o_valid only in cycle T+33, o_result=14; REMU same operands -> 2.
REQ-031 DIV 0xFFFFFFF9/2 (-7/2) -> o_result=0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-032 DIVU 5/0 -> o_valid in cycle T+1, o_result=0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in T+1, REM -> 0.
REQ-033 Accept then i_kill=1 at cycle T+10 -> state IDLE at T+11, o_ready=1, no o_valid ever for that op; new DIVU 9/3 accepted at T+11 -> 3 at T+44.
REQ-034 Assert i_rst at T+20 of a DIVU 0xFFFFFFFF/1 -> o_valid never pulses, o_result=0 after reset, o_ready=1 one cycle after release.
REQ-035 Two back-to-back DIVU requests with i_valid held high -> second accepted in IDLE cycle after first DONE; results in order, each o_valid exactly one cycle.

Source files
------------

// File: rtl/div_if.sv
// Request/response bundle for the RV32M divide unit: request fields, flush,
// and the ready/valid/result return path.
interface div_if;
    logic        i_valid;
    logic [1:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_kill;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;

    modport master (
        output i_valid, i_op, i_rs1, i_rs2, i_kill,
        input  o_ready, o_valid, o_result
    );

    modport slave (
        input  i_valid, i_op, i_rs1, i_rs2, i_kill,
        output o_ready, o_valid, o_result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): one restoring step per cycle,
// with divide-by-zero and signed-overflow resolved at accept time.
module div_unit (
    input  logic  i_clk,
    input  logic  i_rst,
    div_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dvs_r;
    logic [31:0] result_r;
    logic        is_rem_r;
    logic        neg_q_r;
    logic        neg_r_r;

    logic        signed_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic        div_zero_s;
    logic        ovf_s;
    logic [32:0] shift_s;
    logic [32:0] diff_s;
    logic [31:0] final_s;
    logic        done_s;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    // Operand decode, datapath step and sign-corrected result.
    always_comb begin
        signed_s   = ~bus.i_op[0];
        a_mag_s    = (signed_s && bus.i_rs1[31]) ? neg32(bus.i_rs1) : bus.i_rs1;
        b_mag_s    = (signed_s && bus.i_rs2[31]) ? neg32(bus.i_rs2) : bus.i_rs2;
        div_zero_s = (bus.i_rs2 == 32'd0);
        ovf_s      = signed_s && (bus.i_rs1 == 32'h8000_0000) && (bus.i_rs2 == 32'hFFFF_FFFF);
        shift_s    = {rem_r, quo_r[31]};
        diff_s     = shift_s - {1'b0, dvs_r};
        if (is_rem_r) begin
            final_s = neg_r_r ? neg32(rem_r) : rem_r;
        end else begin
            final_s = neg_q_r ? neg32(quo_r) : quo_r;
        end
        done_s = (state_r == S_DONE) && !i_rst && !bus.i_kill;
    end

    // A killed DONE neither pulses nor exposes its result.
    assign bus.o_ready  = (state_r == S_IDLE) && !i_rst;
    assign bus.o_valid  = done_s;
    assign bus.o_result = done_s ? final_s : result_r;

    // Control FSM and datapath registers; reset beats kill beats everything else.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= S_IDLE;
            cnt_r    <= 5'd0;
            quo_r    <= 32'd0;
            rem_r    <= 32'd0;
            dvs_r    <= 32'd0;
            result_r <= 32'd0;
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
        end else if (bus.i_kill) begin
            state_r <= S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        is_rem_r <= bus.i_op[1];
                        if (div_zero_s) begin
                            quo_r   <= 32'hFFFF_FFFF;
                            rem_r   <= bus.i_rs1;
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                            state_r <= S_DONE;
                        end else if (ovf_s) begin
                            quo_r   <= 32'h8000_0000;
                            rem_r   <= 32'd0;
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                            state_r <= S_DONE;
                        end else begin
                            quo_r   <= a_mag_s;
                            rem_r   <= 32'd0;
                            dvs_r   <= b_mag_s;
                            neg_q_r <= signed_s && (bus.i_rs1[31] ^ bus.i_rs2[31]);
                            neg_r_r <= signed_s && bus.i_rs1[31];
                            cnt_r   <= 5'd31;
                            state_r <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    // Dividend bits shift out of quo_r as quotient bits shift in.
                    quo_r <= {quo_r[30:0], ~diff_s[32]};
                    rem_r <= diff_s[32] ? shift_s[31:0] : diff_s[31:0];
                    if (cnt_r == 5'd0) begin
                        state_r <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                S_DONE: begin
                    result_r <= final_s;
                    state_r  <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule
